sext_arbiter: RTL

Round-robin scheduler that shares one variable-width sign-extension datapath among NUM_REQ requesters. Each requester presents a raw field of 1..FROM_WIDTH significant bits plus its length over a valid/ready handshake. The block grants one requester per cycle, sign-extends the field to TO_WIDTH bits and holds the result in a single output register with its own valid/ready handshake. It sits between decode-stage immediate producers and their consumers.

---
 rtl/sext_pkg.sv | 10 +
 rtl/sext_var.sv | 21 ++
 rtl/sext_arbiter.sv | 72 +++++++
 3 files changed

// File: rtl/sext_pkg.sv
// sext_pkg: shared types and helpers for the sign-extension arbiter.
package sext_pkg;
  typedef enum logic {EMPTY, FULL} state_e;
  function automatic int lw(input int fw);
    return $clog2(fw + 1);
  endfunction
  function automatic int rr_inc(input int p, input int n);
    return (p + 1) % n;
  endfunction
endpackage

// File: rtl/sext_var.sv
// sext_var: combinational variable-width sign extension of an LSB-aligned field.
module sext_var import sext_pkg::*; #(
  parameter int FROM_WIDTH = 16,
  parameter int TO_WIDTH = 32,
  localparam int LW = lw(FROM_WIDTH),
  localparam int SW = $clog2(TO_WIDTH + 1)
) (
  input  logic [FROM_WIDTH-1:0] field,
  input  logic [LW-1:0]         len,
  output logic [TO_WIDTH-1:0]   ext
);
  logic [SW-1:0] l, sh;
  logic [TO_WIDTH-1:0] fz;
  // Left-justify the significant bits, then arithmetic-shift back to replicate the sign.
  always_comb begin
    l = (len == '0 || len > LW'(FROM_WIDTH)) ? SW'(FROM_WIDTH) : SW'(len);
    sh = SW'(TO_WIDTH) - l;
    fz = TO_WIDTH'(field);
    ext = $signed(fz << sh) >>> sh;
  end
endmodule

// File: rtl/sext_arbiter.sv
// sext_arbiter: round-robin share of one sign-extension datapath among NUM_REQ
// requesters, with a single registered valid/ready output stage.
module sext_arbiter import sext_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int FROM_WIDTH = 16,
  parameter int TO_WIDTH = 32,
  localparam int LW = lw(FROM_WIDTH),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*FROM_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*LW-1:0]      req_len,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TO_WIDTH-1:0]        out_data,
  output logic [IW-1:0]              out_id
);
  state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, id_q, id_d, win, idx;
  logic [TO_WIDTH-1:0] data_q, data_d, ext;
  logic [FROM_WIDTH-1:0] field;
  logic [LW-1:0] len;
  logic found, can_accept, xfer;
  // Scan downward in distance so the nearest candidate at or after rr_q wins.
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    field = FROM_WIDTH'(req_data >> (FROM_WIDTH * int'(win)));
    len = LW'(req_len >> (LW * int'(win)));
    can_accept = state_q == EMPTY || out_ready;
    xfer = rst_n && can_accept && found;
    req_ready = xfer ? (NUM_REQ'(1) << win) : '0;
    state_d = xfer ? FULL : (out_ready ? EMPTY : state_q);
    rr_d = xfer ? IW'(rr_inc(int'(win), NUM_REQ)) : rr_q;
    data_d = xfer ? ext : data_q;
    id_d = xfer ? win : id_q;
  end
  sext_var #(.FROM_WIDTH(FROM_WIDTH), .TO_WIDTH(TO_WIDTH)) u_var (
    .field(field),
    .len(len),
    .ext(ext)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rr_q <= '0;
      data_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      data_q <= data_d;
      id_q <= id_d;
    end
  end
  assign out_valid = state_q == FULL;
  assign out_data = data_q;
  assign out_id = id_q;
endmodule
